// File: rtl/imem_pkg.sv
// Shared types and helpers for the loadable instruction memory.
// The optional parity store is enabled by defining IMEM_PARITY_EN.
package imem_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        LOAD  = 2'd1,
        RUN   = 2'd2
    } imem_state_e;

    localparam logic [15:0] NOP_WORD_DEFAULT = 16'h0000;

    // Even parity: the stored bit makes the XOR of word plus bit equal zero.
    function automatic logic even_parity(input logic [63:0] w);
        return ^w;
    endfunction

endpackage

// File: rtl/imem_array.sv
// Single-port synchronous RAM with write enable and registered, enable-gated read.
// Contents are not reset so the array maps onto block RAM.
module imem_array #(
    parameter int W     = 16,
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic          re,
    input  logic [AW-1:0] addr,
    input  logic [W-1:0]  wdata,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem_reg [DEPTH];
    logic [W-1:0] rdata_reg;

    // Read data only updates on a read, so the output holds between fetches.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_reg[addr] <= wdata;
        end
        if (re) begin
            rdata_reg <= mem_reg[addr];
        end
    end

    assign rdata = rdata_reg;

endmodule

// File: rtl/imem_loadable.sv
// Writable instruction memory: registered fetch port indexed by byte PC, valid/ready loader port.
// Define IMEM_PARITY_EN to store an even-parity bit per word and flag read mismatches.
module imem_loadable
    import imem_pkg::*;
#(
    parameter int                 INSTR_W  = 16,
    parameter int                 PC_W     = 16,
    parameter int                 DEPTH    = 256,
    parameter logic [INSTR_W-1:0] NOP_WORD = INSTR_W'(NOP_WORD_DEFAULT)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     fetch_req,
    input  logic [PC_W-1:0]          pc,
    output logic [INSTR_W-1:0]       instruction,
    output logic                     instr_valid,
    output logic                     fetch_fault,
    output logic                     stall,
    input  logic                     load_start,
    input  logic                     ld_valid,
    output logic                     ld_ready,
    input  logic [INSTR_W-1:0]       ld_data,
    input  logic                     ld_last,
    output logic [$clog2(DEPTH):0]   ld_count,
    output logic                     ld_overflow,
    output logic                     parity_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
`ifdef IMEM_PARITY_EN
    localparam int MW = INSTR_W + 1;
`else
    localparam int MW = INSTR_W;
`endif

    imem_state_e   state_reg, state_next;
    logic [CW-1:0] ld_count_reg, ld_count_next;
    logic          ld_overflow_reg, ld_overflow_next;
    logic          valid_reg, fault_reg, sel_ram_reg;

    logic [PC_W-2:0] word_idx;
    logic            fetch_ok;
    logic            ld_full, ld_take, start_taken;
    logic            ram_we, ram_re;
    logic [AW-1:0]   ram_addr;
    logic [MW-1:0]   ram_wdata, ram_rdata;

    assign word_idx = pc[PC_W-1:1];
    assign fetch_ok = ~pc[0] && ((word_idx >> AW) == '0);
    assign ld_full  = (ld_count_reg == CW'(DEPTH));
    assign ld_ready = (state_reg == LOAD) && !ld_full;
    assign ld_take  = ld_valid && ld_ready;

    always_comb begin
        state_next       = state_reg;
        ld_count_next    = ld_count_reg;
        ld_overflow_next = ld_overflow_reg;
        start_taken      = 1'b0;
        case (state_reg)
            EMPTY: begin
                if (load_start) begin
                    start_taken = 1'b1;
                    state_next  = LOAD;
                end
            end
            LOAD: begin
                if (ld_take) begin
                    ld_count_next = ld_count_reg + CW'(1);
                end
                if (ld_valid && ld_full) begin
                    ld_overflow_next = 1'b1;
                end
                // Last word ends the load whether it was stored or dropped.
                if (ld_valid && ld_last) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (load_start) begin
                    start_taken = 1'b1;
                    state_next  = LOAD;
                end
            end
            default: state_next = EMPTY;
        endcase
        if (start_taken) begin
            ld_count_next    = '0;
            ld_overflow_next = 1'b0;
        end
    end

    assign ram_we   = ld_take;
    assign ram_re   = fetch_req && (state_reg == RUN) && fetch_ok;
    assign ram_addr = (state_reg == LOAD) ? ld_count_reg[AW-1:0] : word_idx[AW-1:0];
`ifdef IMEM_PARITY_EN
    assign ram_wdata = {even_parity(64'(ld_data)), ld_data};
`else
    assign ram_wdata = ld_data;
`endif

    imem_array #(
        .W     (MW),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .clk   (clk),
        .we    (ram_we),
        .re    (ram_re),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= EMPTY;
            ld_count_reg    <= '0;
            ld_overflow_reg <= 1'b0;
            valid_reg       <= 1'b0;
            fault_reg       <= 1'b0;
            sel_ram_reg     <= 1'b0;
        end else begin
            state_reg       <= state_next;
            ld_count_reg    <= ld_count_next;
            ld_overflow_reg <= ld_overflow_next;
            valid_reg       <= fetch_req;
            fault_reg       <= fetch_req && (state_reg == RUN) && !fetch_ok;
            if (fetch_req) begin
                sel_ram_reg <= ram_re;
            end
        end
    end

    assign instr_valid = valid_reg;
    assign stall       = (state_reg != RUN);
    assign ld_count    = ld_count_reg;
    assign ld_overflow = ld_overflow_reg;

`ifdef IMEM_PARITY_EN
    logic par_bad;
    logic parity_err_reg;

    assign par_bad = sel_ram_reg &&
                     (even_parity(64'(ram_rdata[INSTR_W-1:0])) != ram_rdata[INSTR_W]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            parity_err_reg <= 1'b0;
        end else if (start_taken) begin
            parity_err_reg <= 1'b0;
        end else if (valid_reg && par_bad) begin
            parity_err_reg <= 1'b1;
        end
    end

    assign instruction = (sel_ram_reg && !par_bad) ? ram_rdata[INSTR_W-1:0] : NOP_WORD;
    assign fetch_fault = fault_reg || (valid_reg && par_bad);
    assign parity_err  = parity_err_reg || (valid_reg && par_bad);
`else
    assign instruction = sel_ram_reg ? ram_rdata : NOP_WORD;
    assign fetch_fault = fault_reg;
    assign parity_err  = 1'b0;
`endif

endmodule

// File: tb/tb_imem_loadable.sv
// Scoreboard bench for imem_loadable: fetch expectations are queued at issue and checked on instr_valid.
// Define IMEM_PARITY_EN to also exercise the parity store.
module tb_imem_loadable;

    localparam int DEPTH = 256;
    localparam logic [15:0] NOP = 16'h0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        fetch_req = 1'b0;
    logic [15:0] pc = '0;
    logic [15:0] instruction;
    logic        instr_valid, fetch_fault, stall;
    logic        load_start = 1'b0;
    logic        ld_valid = 1'b0;
    logic        ld_ready;
    logic [15:0] ld_data = '0;
    logic        ld_last = 1'b0;
    logic [8:0]  ld_count;
    logic        ld_overflow, parity_err;

    imem_loadable #(
        .INSTR_W (16),
        .PC_W    (16),
        .DEPTH   (DEPTH)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .fetch_req   (fetch_req),
        .pc          (pc),
        .instruction (instruction),
        .instr_valid (instr_valid),
        .fetch_fault (fetch_fault),
        .stall       (stall),
        .load_start  (load_start),
        .ld_valid    (ld_valid),
        .ld_ready    (ld_ready),
        .ld_data     (ld_data),
        .ld_last     (ld_last),
        .ld_count    (ld_count),
        .ld_overflow (ld_overflow),
        .parity_err  (parity_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic [15:0] instr;
        logic        fault;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_pass = 0;
    int          cyc = 0;
    logic [15:0] last_instr = NOP;

    logic [15:0] exp_mem [DEPTH];
    bit          exp_bad [DEPTH];
    bit          model_run = 0;
    int          mcount = 0;
    bit          movf = 0;
    logic [15:0] prog[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc++;

    // Scoreboard consumer: a due entry must appear as a valid pulse; otherwise output must idle and hold.
    always @(negedge clk) begin
        if (rst_n) begin
            if (sb.size() > 0 && sb[0].due == cyc) begin
                exp_t e;
                e = sb.pop_front();
                check("instr_valid", 32'(instr_valid), 32'd1);
                check("instruction", 32'(instruction), 32'(e.instr));
                check("fetch_fault", 32'(fetch_fault), 32'(e.fault));
                $display("fetch result: instr=%h fault=%0d", instruction, fetch_fault);
                last_instr = e.instr;
            end else begin
                check("idle_valid", 32'(instr_valid), 32'd0);
                check("idle_hold", 32'(instruction), 32'(last_instr));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic exp_t model_fetch(input logic [15:0] p);
        exp_t e;
        int   idx;
        idx     = int'(p >> 1);
        e.due   = cyc + 1;
        e.instr = NOP;
        e.fault = 1'b0;
        if (model_run) begin
            if (p[0] || idx >= DEPTH) begin
                e.fault = 1'b1;
            end else if (exp_bad[idx]) begin
                e.fault = 1'b1;
            end else begin
                e.instr = exp_mem[idx];
            end
        end
        return e;
    endfunction

    task automatic issue(input logic [15:0] p);
        fetch_req = 1'b1;
        pc        = p;
        sb.push_back(model_fetch(p));
    endtask

    task automatic fetch1(input logic [15:0] p);
        issue(p);
        tick();
        fetch_req = 1'b0;
    endtask

    task automatic start_load();
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        model_run  = 0;
        mcount     = 0;
        movf       = 0;
        check("start_count", 32'(ld_count), 32'd0);
        check("start_ovf", 32'(ld_overflow), 32'd0);
    endtask

    task automatic stream(input bit end_with_last);
        for (int i = 0; i < prog.size(); i++) begin
            ld_valid = 1'b1;
            ld_data  = prog[i];
            ld_last  = end_with_last && (i == prog.size() - 1);
            check("ld_ready", 32'(ld_ready), 32'(mcount < DEPTH));
            tick();
            if (mcount < DEPTH) begin
                exp_mem[mcount] = prog[i];
                exp_bad[mcount] = 0;
                mcount++;
            end else begin
                movf = 1;
            end
        end
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        if (end_with_last) model_run = 1;
        $display("load: %0d words presented, count=%0d overflow=%0d", prog.size(), ld_count, ld_overflow);
    endtask

    task automatic drain();
        repeat (3) tick();
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            exp_mem[i] = NOP;
            exp_bad[i] = 0;
        end

        // Reset values
        #3;
        check("rst_instr", 32'(instruction), 32'(NOP));
        check("rst_valid", 32'(instr_valid), 32'd0);
        check("rst_fault", 32'(fetch_fault), 32'd0);
        check("rst_ready", 32'(ld_ready), 32'd0);
        check("rst_count", 32'(ld_count), 32'd0);
        check("rst_ovf", 32'(ld_overflow), 32'd0);
        check("rst_perr", 32'(parity_err), 32'd0);
        check("rst_stall", 32'(stall), 32'd1);
        tick();
        rst_n = 1'b1;
        tick();

        // Fetch before any load returns NOP, no fault, core stalled
        fetch1(16'h0000);
        check("empty_stall", 32'(stall), 32'd1);
        drain();

        // Five-word program
        start_load();
        prog = '{16'h0000, 16'h3190, 16'h33BE, 16'h32EF, 16'h7200};
        stream(1);
        check("prog_count", 32'(ld_count), 32'd5);
        check("prog_stall", 32'(stall), 32'd0);
        for (int i = 1; i <= 4; i++) begin
            issue(16'(2 * i));
            tick();
        end
        fetch_req = 1'b0;
        drain();

        // Misaligned and out-of-range fetches
        fetch1(16'h0003);
        fetch1(16'(2 * DEPTH));
        fetch1(16'h0000);
        drain();

        // Fetch taken with load_start: old content returned
        issue(16'h0002);
        load_start = 1'b1;
        tick();
        fetch_req  = 1'b0;
        load_start = 1'b0;
        model_run  = 0;
        mcount     = 0;
        movf       = 0;
        check("reload_count", 32'(ld_count), 32'd0);
        check("reload_stall", 32'(stall), 32'd1);

        // Overflow load: DEPTH+2 words, last on final
        prog.delete();
        for (int i = 0; i < DEPTH + 2; i++) prog.push_back(16'((i * 37) ^ 16'h5A00));
        stream(1);
        check("ovf_count", 32'(ld_count), 32'(DEPTH));
        check("ovf_flag", 32'(ld_overflow), 32'(movf));
        check("ovf_stall", 32'(stall), 32'd0);
        fetch1(16'(2 * (DEPTH - 1)));
        fetch1(16'h0000);
        fetch1(16'h0010);
        drain();

        // Reset in the middle of a load
        start_load();
        prog = '{16'h1111, 16'h2222, 16'h3333};
        stream(0);
        fetch1(16'h0000);
        check("load_stall", 32'(stall), 32'd1);
        drain();
        rst_n = 1'b0;
        model_run  = 0;
        last_instr = NOP;
        #1;
        check("mid_rst_count", 32'(ld_count), 32'd0);
        check("mid_rst_stall", 32'(stall), 32'd1);
        check("mid_rst_ready", 32'(ld_ready), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        fetch1(16'h0000);
        check("post_rst_stall", 32'(stall), 32'd1);
        drain();

`ifdef IMEM_PARITY_EN
        // Corrupt one stored parity bit and fetch it
        start_load();
        prog = '{16'h0000, 16'h3190, 16'h33BE, 16'h32EF, 16'h7200};
        stream(1);
        dut.u_array.mem_reg[1][16] = ~dut.u_array.mem_reg[1][16];
        exp_bad[1] = 1;
        fetch1(16'h0002);
        fetch1(16'h0004);
        drain();
        check("perr_sticky", 32'(parity_err), 32'd1);
        start_load();
        check("perr_cleared", 32'(parity_err), 32'd0);
        stream(1);
        fetch1(16'h0002);
        drain();
`endif

        check("sb_drain", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
